// File: rtl/insmem_fetch_loader.sv
// Byte-addressed big-endian instruction memory with a registered fetch port and byte-serial loader.
// Define INSMEM_ALIGN_CHECK_EN to flag misaligned fetches instead of forcing word alignment.
module insmem_fetch_loader #(
    parameter int unsigned DEPTH_BYTES = 128,
    parameter int unsigned PC_OFFSET   = 4,
    parameter logic [31:0] HALT_WORD   = 32'hFC000000
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic [31:0]                  PC,
    input  logic                         fetch_req,
    output logic                         fetch_ready,
    output logic                         fetch_valid,
    output logic [31:0]                  instruction,
    output logic                         fetch_err,
    input  logic                         load_start,
    input  logic                         load_valid,
    input  logic [7:0]                   load_data,
    input  logic                         load_last,
    output logic                         load_ready,
    output logic                         load_busy,
    output logic [$clog2(DEPTH_BYTES):0] load_count,
    output logic                         load_err
);
    localparam int unsigned IdxW     = $clog2(DEPTH_BYTES);
    localparam int unsigned CntW     = IdxW + 1;
    localparam logic [31:0] LastBase = 32'(DEPTH_BYTES - 4);

    typedef enum logic {StIdle, StLoad} stateT;

    stateT           stateQ, stateD;
    logic [CntW-1:0] cntQ, cntD;
    logic            loadErrQ, loadErrD;
    logic            memWe;
    logic [7:0]      mem [DEPTH_BYTES];

    logic            fetchAcc;
    logic            fetchFault;
    logic [31:0]     fetchAddr;
    logic [IdxW-1:0] rdIdx;
    logic [31:0]     rdWord;
    logic            fetchValidQ, fetchErrQ;
    logic [31:0]     instrQ;

    // The write pointer and the byte count always move together, so one counter serves both.
    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        loadErrD = loadErrQ;
        memWe    = 1'b0;
        if (load_start) begin
            stateD   = StLoad;
            cntD     = '0;
            loadErrD = 1'b0;
        end else if (stateQ == StLoad && load_valid) begin
            if (cntQ == CntW'(DEPTH_BYTES)) begin
                loadErrD = 1'b1;
                stateD   = StIdle;
            end else begin
                memWe = 1'b1;
                cntD  = cntQ + CntW'(1);
                if (load_last) begin
                    stateD = StIdle;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stateQ   <= StIdle;
            cntQ     <= '0;
            loadErrQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            loadErrQ <= loadErrD;
        end
    end

    // No reset on the array: contents survive Reset, and Reset forces IDLE so memWe stays low.
    always_ff @(posedge CLK) begin
        if (memWe) begin
            mem[cntQ[IdxW-1:0]] <= load_data;
        end
    end

    assign fetch_ready = (stateQ == StIdle) && !load_start;
    assign fetchAcc    = fetch_req && fetch_ready;
    assign fetchAddr   = PC - 32'(PC_OFFSET);

`ifdef INSMEM_ALIGN_CHECK_EN
    assign fetchFault = (fetchAddr > LastBase) || (fetchAddr[1:0] != 2'b00);
    assign rdIdx      = fetchAddr[IdxW-1:0];
`else
    logic [31:0] baseAddr;
    assign baseAddr   = fetchAddr & ~32'h3;
    assign fetchFault = baseAddr > LastBase;
    assign rdIdx      = baseAddr[IdxW-1:0];
`endif

    assign rdWord = {mem[rdIdx], mem[rdIdx + IdxW'(1)], mem[rdIdx + IdxW'(2)],
                     mem[rdIdx + IdxW'(3)]};

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            fetchValidQ <= 1'b0;
            instrQ      <= 32'h0;
            fetchErrQ   <= 1'b0;
        end else begin
            fetchValidQ <= fetchAcc;
            if (fetchAcc) begin
                instrQ    <= fetchFault ? HALT_WORD : rdWord;
                fetchErrQ <= fetchFault;
            end
        end
    end

    assign fetch_valid = fetchValidQ;
    assign instruction = instrQ;
    assign fetch_err   = fetchErrQ;
    assign load_ready  = (stateQ == StLoad);
    assign load_busy   = (stateQ == StLoad);
    assign load_count  = cntQ;
    assign load_err    = loadErrQ;
endmodule

// File: tb/tb_insmem_fetch_loader.sv
// Directed bench for insmem_fetch_loader: 128-byte instance for load/fetch/priority/reset,
// 8-byte instance for loader overflow.
module tb_insmem_fetch_loader;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        Reset;
    logic [31:0] PC;
    logic        fetch_req, fetch_ready, fetch_valid, fetch_err;
    logic [31:0] instruction;
    logic        load_start, load_valid, load_last, load_ready, load_busy, load_err;
    logic [7:0]  load_data;
    logic [7:0]  load_count;

    logic [31:0] PC8;
    logic        fetch_req8, fetch_ready8, fetch_valid8, fetch_err8;
    logic [31:0] instruction8;
    logic        load_start8, load_valid8, load_last8, load_ready8, load_busy8, load_err8;
    logic [7:0]  load_data8;
    logic [3:0]  load_count8;

    insmem_fetch_loader #(.DEPTH_BYTES(128)) dut (
        .CLK(CLK), .Reset(Reset), .PC(PC), .fetch_req(fetch_req), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .instruction(instruction), .fetch_err(fetch_err),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_busy(load_busy),
        .load_count(load_count), .load_err(load_err)
    );

    insmem_fetch_loader #(.DEPTH_BYTES(8)) dut8 (
        .CLK(CLK), .Reset(Reset), .PC(PC8), .fetch_req(fetch_req8), .fetch_ready(fetch_ready8),
        .fetch_valid(fetch_valid8), .instruction(instruction8), .fetch_err(fetch_err8),
        .load_start(load_start8), .load_valid(load_valid8), .load_data(load_data8),
        .load_last(load_last8), .load_ready(load_ready8), .load_busy(load_busy8),
        .load_count(load_count8), .load_err(load_err8)
    );

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        logic        chkInstr;
    } fetchVecT;

    localparam int NumVec = 10;
    fetchVecT    vecs [NumVec];
    logic [7:0]  prog [8];

    initial begin
        prog = '{8'h40, 8'h01, 8'h00, 8'h0A, 8'h40, 8'h02, 8'h00, 8'h0C};
        vecs[0] = '{32'd4,          32'h4001000A, 1'b0, 1'b1};
        vecs[1] = '{32'd8,          32'h4002000C, 1'b0, 1'b1};
        vecs[2] = '{32'd132,        32'hFC000000, 1'b1, 1'b1};
        vecs[3] = '{32'd0,          32'hFC000000, 1'b1, 1'b1};
        vecs[4] = '{32'd128,        32'h0,        1'b0, 1'b0};
        vecs[5] = '{32'h8000_0000,  32'hFC000000, 1'b1, 1'b1};
`ifdef INSMEM_ALIGN_CHECK_EN
        vecs[6] = '{32'd6,          32'hFC000000, 1'b1, 1'b1};
        vecs[7] = '{32'd5,          32'hFC000000, 1'b1, 1'b1};
        vecs[8] = '{32'd10,         32'hFC000000, 1'b1, 1'b1};
`else
        vecs[6] = '{32'd6,          32'h4001000A, 1'b0, 1'b1};
        vecs[7] = '{32'd5,          32'h4001000A, 1'b0, 1'b1};
        vecs[8] = '{32'd10,         32'h4002000C, 1'b0, 1'b1};
`endif
        vecs[9] = '{32'd8,          32'h4002000C, 1'b0, 1'b1};

        Reset = 1'b1; PC = 0; fetch_req = 0; load_start = 0; load_valid = 0; load_data = 0;
        load_last = 0;
        PC8 = 0; fetch_req8 = 0; load_start8 = 0; load_valid8 = 0; load_data8 = 0;
        load_last8 = 0;
        repeat (2) @(negedge CLK);
        check("rst fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst instruction", instruction, 32'h0);
        check("rst fetch_err", 32'(fetch_err), 32'd0);
        check("rst load_count", 32'(load_count), 32'd0);
        check("rst load_err", 32'(load_err), 32'd0);
        check("rst load_busy", 32'(load_busy), 32'd0);
        check("rst load_ready", 32'(load_ready), 32'd0);
        Reset = 1'b0;

        // load_start beats a simultaneous fetch
        @(negedge CLK);
        load_start = 1; fetch_req = 1; PC = 4;
        #1 check("prio fetch_ready", 32'(fetch_ready), 32'd0);
        @(negedge CLK);
        load_start = 0; fetch_req = 0;
        check("prio load_busy", 32'(load_busy), 32'd1);
        check("prio fetch_valid", 32'(fetch_valid), 32'd0);
        check("prio load_ready", 32'(load_ready), 32'd1);

        // restart from LOAD, then stream the program
        @(negedge CLK);
        load_start = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            load_start = 0; load_valid = 1; load_data = prog[i]; load_last = (i == 7);
        end
        @(negedge CLK);
        load_valid = 0; load_last = 0;
        check("load count", 32'(load_count), 32'd8);
        check("load err", 32'(load_err), 32'd0);
        check("load busy after last", 32'(load_busy), 32'd0);

        // back-to-back fetch table
        for (int i = 0; i <= NumVec; i++) begin
            @(negedge CLK);
            if (i > 0) begin
                check($sformatf("vec%0d valid", i - 1), 32'(fetch_valid), 32'd1);
                if (vecs[i - 1].chkInstr)
                    check($sformatf("vec%0d instr", i - 1), instruction, vecs[i - 1].instr);
                check($sformatf("vec%0d err", i - 1), 32'(fetch_err), 32'(vecs[i - 1].err));
            end
            if (i < NumVec) begin
                PC = vecs[i].pc; fetch_req = 1;
            end else begin
                fetch_req = 0;
            end
        end
        @(negedge CLK);
        check("valid single pulse", 32'(fetch_valid), 32'd0);
        check("instr held", instruction, 32'h4002000C);

        // Reset kills a pending fetch_valid
        @(negedge CLK);
        PC = 4; fetch_req = 1;
        @(posedge CLK);
        #1 fetch_req = 0; Reset = 1;
        #1 check("reset suppresses valid", 32'(fetch_valid), 32'd0);
        @(negedge CLK);
        Reset = 0;

        // Reset mid-load after 3 bytes
        @(negedge CLK);
        load_start = 1;
        @(negedge CLK);
        load_start = 0; load_valid = 1; load_data = 8'hAA;
        @(negedge CLK);
        load_data = 8'hBB;
        @(negedge CLK);
        load_data = 8'hCC;
        @(negedge CLK);
        load_data = 8'hDD; Reset = 1;
        #1 check("midload busy", 32'(load_busy), 32'd0);
        check("midload count", 32'(load_count), 32'd0);
        @(negedge CLK);
        Reset = 0; load_valid = 0;
        @(negedge CLK);
        PC = 4; fetch_req = 1;
        @(negedge CLK);
        fetch_req = 0;
        check("midload fetch valid", 32'(fetch_valid), 32'd1);
        check("midload fetch instr", instruction, 32'hAABBCC0A);
        check("midload fetch err", 32'(fetch_err), 32'd0);

        // Overflow on the 8-byte instance
        @(negedge CLK);
        load_start8 = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            load_start8 = 0;
            if (i == 8) begin
                check("ovf count before 9th", 32'(load_count8), 32'd8);
                check("ovf err before 9th", 32'(load_err8), 32'd0);
                check("ovf busy before 9th", 32'(load_busy8), 32'd1);
            end
            load_valid8 = 1; load_data8 = 8'h11 + 8'(i);
        end
        @(negedge CLK);
        load_valid8 = 0;
        check("ovf err", 32'(load_err8), 32'd1);
        check("ovf count", 32'(load_count8), 32'd8);
        check("ovf busy", 32'(load_busy8), 32'd0);
        PC8 = 4; fetch_req8 = 1;
        @(negedge CLK);
        PC8 = 8;
        check("ovf word0", instruction8, 32'h11121314);
        @(negedge CLK);
        PC8 = 12;
        check("ovf word1", instruction8, 32'h15161718);
        check("ovf word1 err", 32'(fetch_err8), 32'd0);
        @(negedge CLK);
        fetch_req8 = 0;
        check("d8 range instr", instruction8, 32'hFC000000);
        check("d8 range err", 32'(fetch_err8), 32'd1);
        check("ovf err sticky", 32'(load_err8), 32'd1);
        load_start8 = 1;
        @(negedge CLK);
        load_start8 = 0;
        check("err cleared by start", 32'(load_err8), 32'd0);
        check("count cleared by start", 32'(load_count8), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/insmem_fetch_loader.md
# insmem_fetch_loader

Parametrised, byte-addressed, big-endian instruction memory with a registered fetch port and a byte-serial program loader.
- Sits between the PC register and the decoder of the multi-cycle CPU, replacing the fixed 128-byte combinational instruction store.
- Programs are streamed in at run time instead of being hard-coded.
- Fetch uses a one-cycle request/valid handshake.
- Misaligned and out-of-range fetches are flagged, and the HALT word is returned in their place.

## Interface
Parameters:
- DEPTH_BYTES, 128, memory size in bytes; must be a multiple of 4, at least 8
- PC_OFFSET, 4, byte offset subtracted from PC to form the fetch address (PC points past the instruction)
- HALT_WORD, 32'hFC000000, word returned on a faulting fetch

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-high reset
- PC  in  32  fetch program counter
- fetch_req  in  1  fetch request
- fetch_ready  out  1  fetch accepted this cycle when high together with fetch_req
- fetch_valid  out  1  one-cycle pulse; instruction and fetch_err are valid
- instruction  out  32  fetched word: {mem[a], mem[a+1], mem[a+2], mem[a+3]}
- fetch_err  out  1  fault on the returned fetch (range or alignment)
- load_start  in  1  begin a program load at byte 0
- load_valid  in  1  load_data is valid
- load_data  in  8  program byte
- load_last  in  1  marks the final byte of the load
- load_ready  out  1  loader accepts a byte
- load_busy  out  1  loader is in the LOAD state
- load_count  out  $clog2(DEPTH_BYTES)+1  bytes written by the current or last load
- load_err  out  1  overflow on the last load; sticky until the next load_start

## Operation
State machine: IDLE, LOAD.
- IDLE -> LOAD on load_start; ptr and load_count cleared to 0, load_err cleared.
- In LOAD:
  - load_ready = 1.
  - Each beat with load_valid && load_ready writes load_data to mem[ptr], then ptr++ and load_count++.
  - LOAD -> IDLE after a beat carrying load_last.
  - If ptr == DEPTH_BYTES when a beat is offered: the byte is discarded, load_err is set, and the FSM goes to IDLE.
- A load_start asserted while in LOAD restarts the load at 0.

Fetch:
- fetch_ready = (state == IDLE) && !load_start; load_start has priority over a fetch in the same cycle.
- On an accepted fetch:
  - a = PC − PC_OFFSET, computed in 32-bit unsigned arithmetic (wrap-around allowed).
  - Range fault if a > DEPTH_BYTES − 4 (unsigned).
  - On a fault: instruction = HALT_WORD and fetch_err = 1.
  - Otherwise: instruction is the big-endian word at a, and fetch_err = 0.
- Memory contents are not reset. Bytes that have never been loaded read as X in simulation.
- Back-to-back fetches are allowed: one accepted fetch per cycle.

## Timing
- Reset values:
  - state = IDLE, fetch_valid = 0, instruction = 32'h0, fetch_err = 0
  - load_count = 0, load_err = 0, load_busy = 0, load_ready = 0
- Memory array contents are retained across Reset.
- Fetch latency is 1 cycle: a fetch accepted at edge N drives fetch_valid high during cycle N+1 only.
- instruction and fetch_err hold their values until the next fetch_valid.
- A load write at edge N is visible to a fetch accepted at edge N+1 or later.
- Reset during LOAD:
  - FSM goes to IDLE and load_count = 0.
  - Bytes already written are kept.
  - No further bytes are written.
- Reset while a fetch is pending: the pending fetch_valid pulse is suppressed.
- load_busy = (state == LOAD) and is registered.

## Configuration
- INSMEM_ALIGN_CHECK_EN defined:
  - an accepted fetch with a[1:0] != 0 is an alignment fault: instruction = HALT_WORD, fetch_err = 1.
  - An alignment fault and a range fault on the same fetch produce a single fetch_err.
- INSMEM_ALIGN_CHECK_EN undefined:
  - a[1:0] is forced to 00 before the read and the range check.
  - Misalignment never raises fetch_err.

## Test plan
- Load and fetch:
  - Stimulus: reset, load_start, then stream 40 01 00 0A 40 02 00 0C with load_last on the 8th byte; then fetch PC=4, then PC=8 back-to-back.
  - Required response: load_count = 8, load_err = 0; fetch_valid on consecutive cycles with instruction 0x4001000A then 0x4002000C, fetch_err = 0.
- Range fault (DEPTH_BYTES = 128):
  - Stimulus: fetch PC = 132 (a = 128), then PC = 0 (a wraps to 0xFFFFFFFC).
  - Required response: both return instruction 0xFC000000 with fetch_err = 1. PC = 128 (a = 124) reads normally.
- Alignment (INSMEM_ALIGN_CHECK_EN defined, after the first load):
  - Stimulus: fetch PC = 6.
  - Required response: instruction 0xFC000000, fetch_err = 1.
  - Same fetch with the macro undefined: instruction 0x4001000A, fetch_err = 0.
- Overflow (DEPTH_BYTES = 8):
  - Stimulus: stream 9 bytes with no load_last.
  - Required response: load_err = 1 on the 9th beat, load_count = 8, FSM in IDLE, mem[0..7] intact.
- Priority and reset:
  - Stimulus: assert load_start and fetch_req in the same IDLE cycle.
  - Required response: fetch_ready = 0, no fetch_valid, load_busy = 1 next cycle.
  - Stimulus: after 3 bytes, assert Reset mid-load.
  - Required response: load_busy = 0, load_count = 0; a later fetch of PC = 4 returns the 3 written bytes in bits [31:8].
